// File: rtl/dbg_uart_loader_if.sv
// Debug loader bus: UART RX/TX byte handshake, CPU reset control and debug memory write port.
// The loader is the slave side; the environment (UART cores, SoC memory port) is the master side.
interface dbg_uart_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        cpu_n_reset;
    logic        dbg_mem_op;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;
    logic        overrun;

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid, cpu_n_reset, dbg_mem_op, dbg_wren, dbg_adr, dbg_do, overrun
    );

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid, cpu_n_reset, dbg_mem_op, dbg_wren, dbg_adr, dbg_do, overrun
    );
endinterface

// File: rtl/dbg_uart_loader.sv
// In-system UART loader: parses A5-framed H/R/W commands, holds the CPU in reset and writes
// program words over the debug memory port. Define DBG_UART_LOADER_CSUM_EN for a W-frame XOR checksum.
module dbg_uart_loader #(
    parameter int WR_CYCLES = 4,
    parameter int TIMEOUT   = 100000,
    parameter bit BOOT_HOLD = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    dbg_uart_loader_if.slave bus
);
    // state   | meaning
    // IDLE    | waiting for 0xA5 sync
    // CMD     | waiting for command byte
    // ADDR    | collecting 4 address bytes (LE)
    // DATA    | collecting 4 data bytes (LE)
    // CSUM    | checking XOR of addr/data bytes (optional)
    // WRITE   | debug port driving the word write
    // ACK     | response byte offered to UART TX
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_H   = 8'h48;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] ACK_OK  = 8'h06;
    localparam logic [7:0] ACK_NAK = 8'h15;
    localparam int WR_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam int TO_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
`ifdef DBG_UART_LOADER_CSUM_EN
        S_CSUM,
`endif
        S_WRITE,
        S_ACK
    } state_t;

    state_t          r_state;
    logic            r_halted;
    logic            r_cpu_n_reset;
    logic            r_mem_op;
    logic [3:0]      r_wren;
    logic [31:0]     r_adr;
    logic [31:0]     r_do;
    logic [7:0]      r_tx_data;
    logic            r_tx_valid;
    logic            r_overrun;
    logic [1:0]      r_byte_cnt;
    logic [WR_W-1:0] r_wr_cnt;
    logic [TO_W-1:0] r_to_cnt;
`ifdef DBG_UART_LOADER_CSUM_EN
    logic [7:0]      r_csum;
`endif

    logic w_in_frame;
    logic w_to_expired;

`ifdef DBG_UART_LOADER_CSUM_EN
    assign w_in_frame = (r_state == S_CMD) || (r_state == S_ADDR) ||
                        (r_state == S_DATA) || (r_state == S_CSUM);
`else
    assign w_in_frame = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA);
`endif
    // Inter-byte down-counter: reloaded on every byte, frame abandoned when it hits zero idle.
    assign w_to_expired = w_in_frame && !bus.rx_valid && (r_to_cnt == '0);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= S_IDLE;
            r_halted      <= BOOT_HOLD;
            r_cpu_n_reset <= ~BOOT_HOLD;
            r_mem_op      <= 1'b0;
            r_wren        <= 4'h0;
            r_adr         <= 32'h0;
            r_do          <= 32'h0;
            r_tx_data     <= 8'h00;
            r_tx_valid    <= 1'b0;
            r_overrun     <= 1'b0;
            r_byte_cnt    <= 2'd0;
            r_wr_cnt      <= '0;
            r_to_cnt      <= '0;
`ifdef DBG_UART_LOADER_CSUM_EN
            r_csum        <= 8'h00;
`endif
        end else begin
            if (bus.rx_valid)
                r_to_cnt <= TO_W'(TIMEOUT - 1);
            else if (r_to_cnt != '0)
                r_to_cnt <= r_to_cnt - TO_W'(1);

            case (r_state)
                S_IDLE: begin
                    if (bus.rx_valid && bus.rx_data == SYNC)
                        r_state <= S_CMD;
                end
                S_CMD: begin
                    if (bus.rx_valid) begin
                        r_tx_valid <= 1'b1;
                        r_state    <= S_ACK;
                        case (bus.rx_data)
                            CMD_W: begin
                                r_tx_valid <= 1'b0;
                                r_byte_cnt <= 2'd0;
`ifdef DBG_UART_LOADER_CSUM_EN
                                r_csum     <= 8'h00;
`endif
                                r_state    <= S_ADDR;
                            end
                            CMD_H: begin
                                r_halted      <= 1'b1;
                                r_cpu_n_reset <= 1'b0;
                                r_overrun     <= 1'b0;
                                r_tx_data     <= ACK_OK;
                            end
                            CMD_R: begin
                                r_halted      <= 1'b0;
                                r_cpu_n_reset <= 1'b1;
                                r_tx_data     <= ACK_OK;
                            end
                            default: r_tx_data <= ACK_NAK;
                        endcase
                    end else if (w_to_expired) begin
                        r_state <= S_IDLE;
                    end
                end
                S_ADDR: begin
                    if (bus.rx_valid) begin
                        r_adr      <= {bus.rx_data, r_adr[31:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef DBG_UART_LOADER_CSUM_EN
                        r_csum     <= r_csum ^ bus.rx_data;
`endif
                        if (r_byte_cnt == 2'd3)
                            r_state <= S_DATA;
                    end else if (w_to_expired) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (bus.rx_valid) begin
                        r_do       <= {bus.rx_data, r_do[31:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef DBG_UART_LOADER_CSUM_EN
                        r_csum     <= r_csum ^ bus.rx_data;
                        if (r_byte_cnt == 2'd3)
                            r_state <= S_CSUM;
`else
                        if (r_byte_cnt == 2'd3) begin
                            if (r_halted) begin
                                r_mem_op <= 1'b1;
                                r_wren   <= 4'hF;
                                r_wr_cnt <= WR_W'(WR_CYCLES - 1);
                                r_state  <= S_WRITE;
                            end else begin
                                r_tx_data  <= ACK_NAK;
                                r_tx_valid <= 1'b1;
                                r_state    <= S_ACK;
                            end
                        end
`endif
                    end else if (w_to_expired) begin
                        r_state <= S_IDLE;
                    end
                end
`ifdef DBG_UART_LOADER_CSUM_EN
                S_CSUM: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == r_csum && r_halted) begin
                            r_mem_op <= 1'b1;
                            r_wren   <= 4'hF;
                            r_wr_cnt <= WR_W'(WR_CYCLES - 1);
                            r_state  <= S_WRITE;
                        end else begin
                            r_tx_data  <= ACK_NAK;
                            r_tx_valid <= 1'b1;
                            r_state    <= S_ACK;
                        end
                    end else if (w_to_expired) begin
                        r_state <= S_IDLE;
                    end
                end
`endif
                S_WRITE: begin
                    if (bus.rx_valid)
                        r_overrun <= 1'b1;
                    if (r_wr_cnt == '0) begin
                        r_mem_op   <= 1'b0;
                        r_wren     <= 4'h0;
                        r_tx_data  <= ACK_OK;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_ACK;
                    end else begin
                        r_wr_cnt <= r_wr_cnt - WR_W'(1);
                    end
                end
                S_ACK: begin
                    if (bus.rx_valid)
                        r_overrun <= 1'b1;
                    if (bus.tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.tx_data     = r_tx_data;
    assign bus.tx_valid    = r_tx_valid;
    assign bus.cpu_n_reset = r_cpu_n_reset;
    assign bus.dbg_mem_op  = r_mem_op;
    assign bus.dbg_wren    = r_wren;
    assign bus.dbg_adr     = r_adr;
    assign bus.dbg_do      = r_do;
    assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_dbg_uart_loader.sv
// Randomized bench for dbg_uart_loader: frames are built from the protocol rules and the
// expected ACK/NAK, writes, CPU reset and overrun come from a frame-level model.
module tb_dbg_uart_loader;
    localparam int TB_TIMEOUT = 40;
    localparam int TB_WR      = 4;

    typedef logic [7:0] bq_t[$];

    logic CLK = 1'b0;
    logic RESET;

    dbg_uart_loader_if u_bus();

    dbg_uart_loader #(
        .WR_CYCLES(TB_WR),
        .TIMEOUT  (TB_TIMEOUT),
        .BOOT_HOLD(1'b1)
    ) u_dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (u_bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // frame-level model
    bit m_halted;
    bit m_overrun;
    int m_tog;

    // bus monitor
    int          pcyc = 0;
    logic [7:0]  resp_q[$];
    logic [31:0] wq_adr[$];
    logic [31:0] wq_do[$];
    int          wq_len[$];
    int          wq_start[$];
    bit          in_write = 1'b0;
    logic [31:0] cur_adr, cur_do;
    int          cur_len, cur_start;
    int          bus_bad = 0;
    int          tog = 0;
    logic        last_cpu = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge CLK) pcyc <= pcyc + 1;

    always @(negedge CLK) begin
        if (RESET) begin
            in_write = 1'b0;
            last_cpu = u_bus.cpu_n_reset;
        end else begin
            if (u_bus.cpu_n_reset !== last_cpu) tog++;
            last_cpu = u_bus.cpu_n_reset;
            if (u_bus.dbg_mem_op) begin
                if (u_bus.dbg_wren != 4'hF) bus_bad++;
                if (!in_write) begin
                    in_write  = 1'b1;
                    cur_adr   = u_bus.dbg_adr;
                    cur_do    = u_bus.dbg_do;
                    cur_len   = 1;
                    cur_start = pcyc;
                end else begin
                    cur_len++;
                    if (u_bus.dbg_adr != cur_adr || u_bus.dbg_do != cur_do) bus_bad++;
                end
            end else begin
                if (u_bus.dbg_wren != 4'h0) bus_bad++;
                if (in_write) begin
                    wq_adr.push_back(cur_adr);
                    wq_do.push_back(cur_do);
                    wq_len.push_back(cur_len);
                    wq_start.push_back(cur_start);
                    in_write = 1'b0;
                end
            end
            if (u_bus.tx_valid && u_bus.tx_ready) resp_q.push_back(u_bus.tx_data);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        u_bus.rx_data  = b;
        u_bus.rx_valid = 1'b1;
        tick();
        u_bus.rx_valid = 1'b0;
    endtask

    task automatic send_gap();
        int g;
        g = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TB_TIMEOUT - 3) : $urandom_range(0, 2);
        repeat (g) tick();
    endtask

    task automatic clear_mon();
        resp_q.delete();
        wq_adr.delete();
        wq_do.delete();
        wq_len.delete();
        wq_start.delete();
    endtask

    task automatic wait_resp(input string tag, input int n);
        int k;
        k = 0;
        while (resp_q.size() < n && k < 300) begin
            tick();
            k++;
        end
        repeat (4) tick();
        chk({tag, "_nresp"}, 32'(resp_q.size()), 32'(n));
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_cpu_n_reset"}, {31'd0, u_bus.cpu_n_reset}, {31'd0, !m_halted});
        chk({tag, "_overrun"}, {31'd0, u_bus.overrun}, {31'd0, m_overrun});
        chk({tag, "_bus_bad"}, 32'(bus_bad), 32'd0);
    endtask

    function automatic bq_t build_w(input logic [31:0] adr, input logic [31:0] dat, input bit bad);
        bq_t b;
        b.push_back(8'hA5);
        b.push_back(8'h57);
        for (int i = 0; i < 4; i++) b.push_back(adr[8*i +: 8]);
        for (int i = 0; i < 4; i++) b.push_back(dat[8*i +: 8]);
`ifdef DBG_UART_LOADER_CSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 2; i < 10; i++) x ^= b[i];
            b.push_back(bad ? (x ^ 8'h01) : x);
        end
`endif
        return b;
    endfunction

    task automatic w_frame(input logic [31:0] adr, input logic [31:0] dat,
                           input bit bad, input bit ovr, input bit gaps);
        bq_t b;
        bit  ok;
        bit  wr;
        int  last;
        b = build_w(adr, dat, bad);
`ifdef DBG_UART_LOADER_CSUM_EN
        ok = !bad;
`else
        ok = 1'b1;
`endif
        last = 0;
        for (int i = 0; i < b.size(); i++) begin
            send_byte(b[i]);
            if (i == b.size() - 1) last = pcyc;
            else if (gaps) send_gap();
        end
        if (ovr) begin
            send_byte(8'h11);
            m_overrun = 1'b1;
        end
        wr = ok && m_halted;
        wait_resp("w", 1);
        if (resp_q.size() > 0) chk("w_code", {24'd0, resp_q[0]}, wr ? 32'h06 : 32'h15);
        chk("w_nwrites", 32'(wq_adr.size()), wr ? 32'd1 : 32'd0);
        if (wr && wq_adr.size() > 0) begin
            chk("w_adr", wq_adr[0], adr);
            chk("w_do", wq_do[0], dat);
            chk("w_len", 32'(wq_len[0]), 32'(TB_WR));
            chk("w_start", 32'(wq_start[0]), 32'(last));
            chk("w_adr_hold", u_bus.dbg_adr, adr);
            chk("w_do_hold", u_bus.dbg_do, dat);
        end
        check_state("w");
        clear_mon();
    endtask

    task automatic cmd_frame(input logic [7:0] c);
        logic [7:0] code;
        send_byte(8'hA5);
        send_gap();
        send_byte(c);
        case (c)
            8'h48: begin
                if (!m_halted) m_tog++;
                m_halted  = 1'b1;
                m_overrun = 1'b0;
                code      = 8'h06;
            end
            8'h52: begin
                if (m_halted) m_tog++;
                m_halted = 1'b0;
                code     = 8'h06;
            end
            8'h57:   code = 8'h00;
            default: code = 8'h15;
        endcase
        wait_resp("cmd", 1);
        if (resp_q.size() > 0) chk("cmd_code", {24'd0, resp_q[0]}, {24'd0, code});
        chk("cmd_nwrites", 32'(wq_adr.size()), 32'd0);
        check_state("cmd");
        clear_mon();
    endtask

    task automatic send_garbage();
        int n;
        logic [7:0] g;
        n = $urandom_range(0, 2);
        repeat (n) begin
            g = 8'($urandom());
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g);
        end
    endtask

    initial begin
        logic [31:0] prog [7];
        bq_t         b;
        logic [7:0]  c;
        int          op;

        prog[0] = 32'h00010137; prog[1] = 32'hFF010113; prog[2] = 32'h00020537;
        prog[3] = 32'h08850513; prog[4] = 32'h00A12623; prog[5] = 32'h00C12583;
        prog[6] = 32'h0000006F;

        RESET          = 1'b1;
        u_bus.rx_data  = 8'h00;
        u_bus.rx_valid = 1'b0;
        u_bus.tx_ready = 1'b1;
        m_halted       = 1'b1;
        m_overrun      = 1'b0;
        m_tog          = 0;
        repeat (3) tick();
        chk("rst_cpu_n_reset", {31'd0, u_bus.cpu_n_reset}, 32'd0);
        chk("rst_mem_op", {31'd0, u_bus.dbg_mem_op}, 32'd0);
        chk("rst_wren", {28'd0, u_bus.dbg_wren}, 32'd0);
        chk("rst_adr", u_bus.dbg_adr, 32'd0);
        chk("rst_do", u_bus.dbg_do, 32'd0);
        chk("rst_tx_valid", {31'd0, u_bus.tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, u_bus.tx_data}, 32'd0);
        chk("rst_overrun", {31'd0, u_bus.overrun}, 32'd0);
        RESET = 1'b0;
        tick();

        // first word of the boot program, then the rest and a run command
        w_frame(32'h00020000, 32'h00010137, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) w_frame(32'h00020000 + 32'(4 * i), prog[i], 1'b0, 1'b0, 1'b1);
        cmd_frame(8'h52);
        w_frame(32'h00020000, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        cmd_frame(8'h48);

        // partial frame abandoned by the inter-byte timeout
        send_byte(8'hA5); send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
        repeat (TB_TIMEOUT + 1) tick();
        cmd_frame(8'h48);

        // response held off, byte arrives during ACK
        u_bus.tx_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h48);
        repeat (3) tick();
        send_byte(8'h11);
        m_overrun = 1'b1;
        tick();
        chk("hold_tx_valid", {31'd0, u_bus.tx_valid}, 32'd1);
        chk("hold_tx_data", {24'd0, u_bus.tx_data}, 32'h06);
        chk("hold_overrun", {31'd0, u_bus.overrun}, 32'd1);
        u_bus.tx_ready = 1'b1;
        wait_resp("hold", 1);
        if (resp_q.size() > 0) chk("hold_code", {24'd0, resp_q[0]}, 32'h06);
        check_state("hold");
        clear_mon();
        cmd_frame(8'h48);

        // tx_ready and rx_valid in the same ACK cycle: the sync byte must be lost
        u_bus.tx_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h99);
        repeat (2) tick();
        u_bus.rx_data  = 8'hA5;
        u_bus.rx_valid = 1'b1;
        u_bus.tx_ready = 1'b1;
        tick();
        u_bus.rx_valid = 1'b0;
        m_overrun = 1'b1;
        send_byte(8'h48);
        wait_resp("simul", 1);
        if (resp_q.size() > 0) chk("simul_code", {24'd0, resp_q[0]}, 32'h15);
        check_state("simul");
        clear_mon();

        // sync/command values inside the payload are plain data
        w_frame(32'hA5A500A5, 32'h57A548A5, 1'b0, 1'b0, 1'b0);
        // write followed immediately by a stray byte
        w_frame(32'h00001000, 32'h12345678, 1'b0, 1'b1, 1'b0);
        cmd_frame(8'h48);

`ifdef DBG_UART_LOADER_CSUM_EN
        w_frame(32'h00020000, 32'h00010137, 1'b0, 1'b0, 1'b0);
        w_frame(32'h00020000, 32'h00010137, 1'b1, 1'b0, 1'b0);
`endif

        // async reset in the middle of a write
        b = build_w(32'h00030000, 32'hCAFEF00D, 1'b0);
        for (int i = 0; i < b.size(); i++) send_byte(b[i]);
        tick();
        #1;
        RESET = 1'b1;
        #1;
        chk("rstw_mem_op", {31'd0, u_bus.dbg_mem_op}, 32'd0);
        chk("rstw_wren", {28'd0, u_bus.dbg_wren}, 32'd0);
        chk("rstw_cpu_n_reset", {31'd0, u_bus.cpu_n_reset}, 32'd0);
        chk("rstw_tx_valid", {31'd0, u_bus.tx_valid}, 32'd0);
        tick();
        RESET     = 1'b0;
        m_halted  = 1'b1;
        m_overrun = 1'b0;
        tick();
        clear_mon();

        // random traffic against the frame model
        for (int it = 0; it < 60; it++) begin
            send_garbage();
            op = $urandom_range(0, 9);
            if (op < 5) begin
                w_frame($urandom(), $urandom(), $urandom_range(0, 4) == 0, 1'b0, 1'b1);
            end else if (op == 5) begin
                w_frame($urandom(), $urandom(), 1'b0, 1'b1, 1'b1);
            end else if (op < 8) begin
                cmd_frame(8'h48);
            end else if (op == 8) begin
                cmd_frame(8'h52);
            end else begin
                c = 8'($urandom());
                if (c == 8'h57 || c == 8'h48 || c == 8'h52) c = 8'h99;
                cmd_frame(c);
            end
        end

        chk("cpu_toggles", 32'(tog), 32'(m_tog));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dbg_uart_loader.md
Name: dbg_uart_loader

Overview:
- Upstream feeder of the SoC debug memory port (dbg_mem_op, dbg_wren, dbg_adr, dbg_do, cpu_n_reset).
- Parses a byte-framed protocol from the UART RX core and holds the CPU in reset while loading.
- Issues 32-bit word writes into program memory, then releases the CPU.
- Returns ACK/NAK bytes to the UART TX core.
- Replaces the bench-side force/release loading with an in-system loader.

Parameters:
- WR_CYCLES, 4, cycles dbg_mem_op/dbg_wren are held per word write (>=1).
- TIMEOUT, 100000, max idle cycles between bytes of one frame before abort (>=2).
- BOOT_HOLD, 1, 1: CPU held in reset after RESET; 0: CPU runs after RESET.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous reset, active-high.
- rx_data  in  8  byte from UART RX core.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- tx_data  out  8  response byte.
- tx_valid  out  1  response request; held until tx_ready.
- tx_ready  in  1  UART TX core accepts tx_data this cycle.
- cpu_n_reset  out  1  0 = CPU held in reset.
- dbg_mem_op  out  1  1 = debug port owns the memory bus.
- dbg_wren  out  4  byte write enables.
- dbg_adr  out  32  write address.
- dbg_do  out  32  write data.
- overrun  out  1  sticky; a byte arrived while it could not be accepted; cleared by RESET or H command.

Behaviour:
- Reset values:
  - cpu_n_reset = ~BOOT_HOLD; halted flag = BOOT_HOLD.
  - dbg_mem_op = 0, dbg_wren = 0, dbg_adr = 0, dbg_do = 0.
  - tx_valid = 0, tx_data = 0, overrun = 0, state = IDLE.
- Frame format: 0xA5 sync, command byte, then payload.
  - 'W' 0x57: addr[7:0], addr[15:8], addr[23:16], addr[31:24], data[7:0] .. data[31:24] (LE).
  - 'H' 0x48: halt, no payload.
  - 'R' 0x52: run, no payload.
- States and transitions:
  - IDLE: on rx_valid with 0xA5 -> CMD. Any other byte is ignored silently.
  - CMD:
    - 0x57 -> ADDR.
    - 0x48 -> halted = 1, cpu_n_reset = 0, overrun cleared, ACK(0x06).
    - 0x52 -> halted = 0, cpu_n_reset = 1 on the next cycle, ACK(0x06).
    - Any other byte -> ACK(0x15).
  - ADDR: 4 bytes shifted into dbg_adr (LE) -> DATA.
  - DATA: 4 bytes into dbg_do (LE) -> WRITE. If not halted, go to ACK(0x15) instead; no bus activity occurs.
  - WRITE:
    - Drive dbg_mem_op = 1 and dbg_wren = 4'hF for exactly WR_CYCLES cycles, starting the cycle after the last data byte.
    - Both drop to 0 together, then -> ACK(0x06).
    - dbg_adr/dbg_do are stable throughout and held afterwards.
  - ACK: tx_valid = 1 with the code; stays until the cycle tx_ready = 1, then -> IDLE.
- Timeout: in CMD/ADDR/DATA (and CSUM), an inter-byte counter resets on each rx_valid. Reaching TIMEOUT -> IDLE, no response; partial dbg_adr/dbg_do contents are don't-care.
- rx_valid during WRITE or ACK: byte dropped, overrun = 1.
- Simultaneous tx_ready and rx_valid in ACK: TX completes, byte dropped, overrun set.
- An 0xA5 byte mid-frame is payload, not a resync.
- RESET asserted mid-WRITE: dbg_wren/dbg_mem_op go to 0 immediately (async), and the CPU state returns to BOOT_HOLD.
- cpu_n_reset never glitches. It changes only on H/R commands or RESET.

Optional Feature:
- Macro: DBG_UART_LOADER_CSUM_EN.
- Defined: 'W' frames carry one extra byte after data, the XOR of the 8 addr/data bytes; state CSUM added after DATA.
  - Match -> WRITE.
  - Mismatch -> ACK(0x15) with no write; dbg_wren is never asserted.
  - Halted check is applied after the checksum check.
- Undefined: no CSUM state; the frame ends at data[31:24].

Test Plan:
- Reset with BOOT_HOLD=1, send A5 57 00 00 02 00 37 01 01 00 -> dbg_adr=0x00020000, dbg_do=0x00010137, dbg_wren=4'hF and dbg_mem_op=1 for exactly 4 cycles, then tx 0x06; cpu_n_reset stays 0.
- Load 7 words 0x20000..0x20018 (lui sp / addi sp,-16 / lui a0 / addi a0,0x88 / sw / lw / j .), send A5 52 -> ACK 0x06, cpu_n_reset=1. In the full SoC, x11 = 0x00020088 and memory 0xFFFC = 0x00020088.
- After A5 52, send a W frame -> tx 0x15, dbg_wren never nonzero. Then A5 48 -> 0x06, cpu_n_reset=0.
- Send A5 57 00 00, then idle TIMEOUT+1 cycles, then A5 48 -> no response to the partial frame, 0x06 for the halt, no write issued.
- Hold tx_ready=0 during ACK and pulse rx_valid with 0x11 -> tx_valid stays 1 with 0x06, overrun=1. Then tx_ready=1 -> IDLE. Also send A5 99 -> 0x15.
- With DBG_UART_LOADER_CSUM_EN: frame with the correct XOR (0x37^0x01^0x01^0x02=0x35) -> write + 0x06. Same frame with CSUM 0x34 -> 0x15, no write.
